fifo_mwmr: RTL and testbench
============================

Name: fifo_mwmr

Overview:
- Multi-write, multi-read, in-order circular queue. Successor to the single-read commit-path FIFO.
- Accepts up to WNUM sparse entries per cycle and compacts them into program order. Presents up to RNUM head entries per cycle for consumer pop.
- Adds what the previous block lacked: backpressure, occupancy count, multi-entry pop and flush.
- Used between execute-side commit producers and a multi-wide retire stage.

Parameters:
- QLEN, 16: queue depth. Power of two, >= max(WNUM, RNUM).
- WNUM, 4: write lanes per cycle. Power of two, >= 1.
- RNUM, 2: read ports per cycle. >= 1.
- TYPE, u64: entry type.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset (asserted at 0).
- flush, input, 1: synchronous queue clear.
- valid, input, WNUM: per-lane write enable. Lanes may be sparse.
- write, input, WNUM x TYPE: per-lane write data.
- wready, output, 1: queue can absorb a full WNUM group this cycle.
- read_valid, output, RNUM: bit i set when entry head+i exists.
- read, output, RNUM x TYPE: entry at head+i.
- read_num, input, $clog2(RNUM)+1: entries popped this cycle, 0..RNUM.
- count, output, $clog2(QLEN)+1: current occupancy.

Behaviour:
- State:
  - head and tail pointers, each $clog2(QLEN)+1 bits, with a wrap bit.
  - count = tail - head, modulo 2^($clog2(QLEN)+1).
  - Storage: QLEN entries; physical address = pointer[$clog2(QLEN)-1:0].
- Reset (reset=0, asynchronous): head=tail=0, so count=0, read_valid=0, wready=1. Storage is not reset; read data is don't-care while its read_valid bit is 0.
- wready = (count <= QLEN-WNUM). This is a function of registered state only; it has no combinational path from valid.
- Write acceptance:
  - A group is accepted only when wready=1 and flush=0.
  - When wready=0, all valid lanes are dropped. Producer must hold.
  - Not an error.
- Compaction:
  - wnum = popcount(valid).
  - The k-th set bit (ascending lane index, k from 0) writes storage[tail+k].
  - tail_next = tail + wnum.
  - Unset lanes are ignored regardless of write data.
- Read ports:
  - read[i] = storage[head+i], with wrap.
  - read_valid[i] = (count > i).
  - Reads come from registered state only: data written in cycle N is first visible in cycle N+1 (latency 1, no bypass).
- Pop:
  - rnum = min(read_num, count).
  - Over-request is clipped, never underflows.
  - read_num > RNUM is illegal and is checked by an assertion.
  - head_next = head + rnum.
- Simultaneous write and pop in one cycle: both apply. count_next = count + wnum - rnum. Freed slots are not reusable the same cycle.
- Flush: head_next = tail_next = 0. Overrides any write and pop in that cycle. Visible as count=0 the next cycle.
- Wrap-around: pointer arithmetic is modulo 2^($clog2(QLEN)+1). Full is (count == QLEN); empty is (count == 0). Both remain distinguishable at every pointer value.
- Reset asserted mid-operation: state clears immediately (asynchronous). On release, the first rising edge behaves as from reset. Stale storage is never exposed, because read_valid=0.
- Invariant: 0 <= count <= QLEN at all times. Carried as an assertion.

Decomposition:
- common package holds:
  - TYPE default u64.
  - Helper function clog2-based pointer typedefs, ptr_t and addr_t, parametrised by QLEN.
- One sub-module, lane_compact:
  - Parametrised by WNUM and TYPE.
  - Input: valid and write.
  - Output: per-offset wen[WNUM], wdata[WNUM] (offset k = k-th set lane) and wnum.
  - Purely combinational.
- Top-level holds the pointers, storage, pop clipping and flush.

Test Plan:
- Reset then idle: after reset, count=0, read_valid=2'b00, wready=1. With read_num=2, count stays 0.
- Sparse compaction: valid=4'b1010, write lanes 1 and 3 = 0xA, 0xB. Next cycle: read[0]=0xA, read[1]=0xB, read_valid=2'b11, count=2.
- Fill and backpressure:
  - Four cycles of valid=4'b1111 with no pops: count reaches 16 and wready=0 once count>12.
  - A fifth group with wready=0 is dropped: count stays 16 and data is unchanged.
- Simultaneous write and pop with wrap:
  - Preload head=tail=14 (push 14, pop 14).
  - Push 4 entries 0x1..0x4, then push 4'b0011 (0x5, 0x6) with read_num=2 in the same cycle.
  - Expected: count=4, read[0]=0x3, read[1]=0x4. Storage wraps through address 0.
- Over-pop clip: count=1, read_num=2. Next cycle: count=0 and head advances by exactly 1.
- Flush and async reset:
  - flush=1 with valid=4'b1111 and read_num=1: next cycle count=0 and the write is discarded.
  - Pulse reset=0 between clock edges while count=5: count=0 immediately, before the next edge.

Source files
------------

// File: rtl/fifo_mwmr_pkg.sv
// Shared types for the multi-write multi-read FIFO: default entry type and
// pointer/address sizing derived from the queue depth.
package fifo_mwmr_pkg;

  typedef logic [63:0] u64_t;

  localparam int QLEN_DEF = 16;

  // Pointer width carries one wrap bit above the storage address.
  function automatic int ptr_bits(input int qlen);
    return $clog2(qlen) + 1;
  endfunction

  typedef logic [ptr_bits(QLEN_DEF)-1:0] ptr_t;
  typedef logic [ptr_bits(QLEN_DEF)-2:0] addr_t;

endpackage

// File: rtl/fifo_mwmr_lane_compact.sv
// Packs sparse write lanes into consecutive offsets in ascending lane order.
// Offset k carries the k-th set lane; wnum is the number of set lanes.
module fifo_mwmr_lane_compact
  import fifo_mwmr_pkg::*;
#(
  parameter int  WNUM = 4,
  parameter type TYPE = u64_t
) (
  input  logic [WNUM-1:0]      valid,
  input  TYPE                  write [WNUM],
  output logic [WNUM-1:0]      wen,
  output TYPE                  wdata [WNUM],
  output logic [$clog2(WNUM):0] wnum
);

  localparam int CW = $clog2(WNUM) + 1;
  localparam int IW = (WNUM > 1) ? $clog2(WNUM) : 1;

  logic [CW-1:0] off;

  // Walk lanes in order, dropping each set lane into the next free offset
  always_comb begin
    wen = '0;
    for (int k = 0; k < WNUM; k++) wdata[k] = '0;
    off = '0;
    for (int i = 0; i < WNUM; i++) begin
      if (valid[i]) begin
        wen[off[IW-1:0]]   = 1'b1;
        wdata[off[IW-1:0]] = write[i];
        off                = off + CW'(1);
      end
    end
    wnum = off;
  end

endmodule

// File: rtl/fifo_mwmr.sv
// In-order circular queue: up to WNUM compacted writes and up to RNUM pops per
// cycle, with backpressure, occupancy count and synchronous flush.
module fifo_mwmr
  import fifo_mwmr_pkg::*;
#(
  parameter int  QLEN = 16,
  parameter int  WNUM = 4,
  parameter int  RNUM = 2,
  parameter type TYPE = u64_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [WNUM-1:0]        valid,
  input  TYPE                    write [WNUM],
  output logic                   wready,
  output logic [RNUM-1:0]        read_valid,
  output TYPE                    read [RNUM],
  input  logic [$clog2(RNUM):0]  read_num,
  output logic [$clog2(QLEN):0]  count
);

  localparam int PW = ptr_bits(QLEN);
  localparam int AW = PW - 1;
  localparam int CW = $clog2(WNUM) + 1;
  localparam int RW = $clog2(RNUM) + 1;

  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   rnum;
  logic            accept;
  logic [WNUM-1:0] wen;
  TYPE             wdata [WNUM];
  logic [CW-1:0]   wnum;
  TYPE             mem [QLEN];

  fifo_mwmr_lane_compact #(
    .WNUM (WNUM),
    .TYPE (TYPE)
  ) u_compact (
    .valid (valid),
    .write (write),
    .wen   (wen),
    .wdata (wdata),
    .wnum  (wnum)
  );

  // Occupancy and space check come from registered pointers only, so wready
  // never depends on this cycle's valid lanes.
  assign count  = tail - head;
  assign wready = (count <= PW'(QLEN - WNUM));
  assign accept = wready & ~flush;
  assign rnum   = (PW'(read_num) > count) ? count : PW'(read_num);

  // Head-relative read window; entries past the occupancy are flagged invalid
  always_comb begin
    read_valid = '0;
    for (int i = 0; i < RNUM; i++) begin
      read[i]       = mem[AW'(head + PW'(i))];
      read_valid[i] = (count > PW'(i));
    end
  end

  // Storage is not reset; stale entries are masked by read_valid
  always_ff @(posedge clk) begin
    for (int k = 0; k < WNUM; k++) begin
      if (accept && wen[k]) mem[AW'(tail + PW'(k))] <= wdata[k];
    end
  end

  // Pointer update: flush wins over any push or pop in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + rnum;
      if (accept) tail <= tail + PW'(wnum);
    end
  end

  a_read_num: assert property (@(posedge clk) disable iff (!reset) read_num <= RW'(RNUM));
  a_count:    assert property (@(posedge clk) disable iff (!reset) count <= PW'(QLEN));

endmodule

// File: tb/tb_fifo_mwmr.sv
// Directed table-driven bench for fifo_mwmr (QLEN=16, WNUM=4, RNUM=2, 64-bit).
module tb_fifo_mwmr;

  typedef struct {
    logic        fl;
    logic [3:0]  v;
    logic [63:0] w0, w1, w2, w3;
    logic [1:0]  rn;
    logic [4:0]  e_cnt;
    logic [1:0]  e_rv;
    logic        e_wr;
    logic [63:0] e_r0, e_r1;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [3:0]  valid;
  logic [63:0] wr [4];
  logic        wready;
  logic [1:0]  read_valid;
  logic [63:0] rd [2];
  logic [1:0]  read_num;
  logic [4:0]  count;

  int nvec = 0;
  int nmis = 0;

  vec_t ta [9];
  vec_t tb [7];

  fifo_mwmr #(.QLEN(16), .WNUM(4), .RNUM(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .valid      (valid),
    .write      (wr),
    .wready     (wready),
    .read_valid (read_valid),
    .read       (rd),
    .read_num   (read_num),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic fl, input logic [3:0] v,
                              input logic [63:0] w0, w1, w2, w3,
                              input logic [1:0] rn, input logic [4:0] cnt,
                              input logic [1:0] rv, input logic wrd,
                              input logic [63:0] r0, r1);
    vec_t t;
    t.fl = fl; t.v = v; t.w0 = w0; t.w1 = w1; t.w2 = w2; t.w3 = w3; t.rn = rn;
    t.e_cnt = cnt; t.e_rv = rv; t.e_wr = wrd; t.e_r0 = r0; t.e_r1 = r1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
      nmis++;
    end
  endtask

  task automatic drive(input logic fl, input logic [3:0] v,
                       input logic [63:0] w0, w1, w2, w3, input logic [1:0] rn);
    flush = fl; valid = v; read_num = rn;
    wr[0] = w0; wr[1] = w1; wr[2] = w2; wr[3] = w3;
  endtask

  // Drive one vector at the falling edge, clock it, check at the next falling edge
  task automatic apply(input string tag, input vec_t t);
    drive(t.fl, t.v, t.w0, t.w1, t.w2, t.w3, t.rn);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 4'b0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0);
    chk({tag, " count"}, 64'(count), 64'(t.e_cnt));
    chk({tag, " read_valid"}, 64'(read_valid), 64'(t.e_rv));
    chk({tag, " wready"}, 64'(wready), 64'(t.e_wr));
    if (t.e_rv[0]) chk({tag, " read0"}, rd[0], t.e_r0);
    if (t.e_rv[1]) chk({tag, " read1"}, rd[1], t.e_r1);
  endtask

  initial begin
    // Idle, sparse compaction, drain, fill to full, dropped group, flush
    ta[0] = mk(0, 4'b0000, 0, 0, 0, 0, 2, 0, 2'b00, 1, 0, 0);
    ta[1] = mk(0, 4'b1010, 64'hDEAD, 64'hA, 64'hBEEF, 64'hB, 0, 2, 2'b11, 1, 64'hA, 64'hB);
    ta[2] = mk(0, 4'b0000, 0, 0, 0, 0, 2, 0, 2'b00, 1, 0, 0);
    ta[3] = mk(0, 4'b1111, 64'h10, 64'h11, 64'h12, 64'h13, 0, 4, 2'b11, 1, 64'h10, 64'h11);
    ta[4] = mk(0, 4'b1111, 64'h14, 64'h15, 64'h16, 64'h17, 0, 8, 2'b11, 1, 64'h10, 64'h11);
    ta[5] = mk(0, 4'b1111, 64'h18, 64'h19, 64'h1A, 64'h1B, 0, 12, 2'b11, 1, 64'h10, 64'h11);
    ta[6] = mk(0, 4'b1111, 64'h1C, 64'h1D, 64'h1E, 64'h1F, 0, 16, 2'b11, 0, 64'h10, 64'h11);
    ta[7] = mk(0, 4'b1111, 64'h99, 64'h99, 64'h99, 64'h99, 0, 16, 2'b11, 0, 64'h10, 64'h11);
    ta[8] = mk(1, 4'b1111, 64'h55, 64'h55, 64'h55, 64'h55, 1, 0, 2'b00, 1, 0, 0);
    // From head=tail=14: wrap through address 0, push+pop together, over-pop clip
    tb[0] = mk(0, 4'b1111, 64'h1, 64'h2, 64'h3, 64'h4, 0, 4, 2'b11, 1, 64'h1, 64'h2);
    tb[1] = mk(0, 4'b0011, 64'h5, 64'h6, 64'hEE, 64'hEE, 2, 4, 2'b11, 1, 64'h3, 64'h4);
    tb[2] = mk(0, 4'b0000, 0, 0, 0, 0, 2, 2, 2'b11, 1, 64'h5, 64'h6);
    tb[3] = mk(0, 4'b0000, 0, 0, 0, 0, 1, 1, 2'b01, 1, 64'h6, 0);
    tb[4] = mk(0, 4'b0000, 0, 0, 0, 0, 2, 0, 2'b00, 1, 0, 0);
    tb[5] = mk(0, 4'b0001, 64'h77, 64'hEE, 64'hEE, 64'hEE, 0, 1, 2'b01, 1, 64'h77, 0);
    tb[6] = mk(0, 4'b1111, 64'h80, 64'h81, 64'h82, 64'h83, 0, 5, 2'b11, 1, 64'h77, 64'h80);

    reset = 1'b0;
    drive(1'b0, 4'b0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("reset count", 64'(count), 64'd0);
    chk("reset read_valid", 64'(read_valid), 64'd0);
    chk("reset wready", 64'(wready), 64'd1);

    for (int i = 0; i < 9; i++) apply($sformatf("ta%0d", i), ta[i]);

    // Preload: push 14 then pop 14 so head=tail=14
    for (int g = 0; g < 4; g++) begin
      drive(1'b0, (g == 3) ? 4'b0011 : 4'b1111, 64'(g * 4), 64'(g * 4 + 1),
            64'(g * 4 + 2), 64'(g * 4 + 3), 2'd0);
      @(posedge clk);
      @(negedge clk);
    end
    drive(1'b0, 4'b0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0);
    chk("preload count14", 64'(count), 64'd14);
    for (int p = 0; p < 7; p++) begin
      read_num = 2'd2;
      @(posedge clk);
      @(negedge clk);
    end
    read_num = 2'd0;
    chk("preload drained", 64'(count), 64'd0);

    for (int i = 0; i < 7; i++) apply($sformatf("tb%0d", i), tb[i]);

    // Asynchronous reset pulse between edges while count=5
    #2 reset = 1'b0;
    #1;
    chk("async reset count", 64'(count), 64'd0);
    chk("async reset read_valid", 64'(read_valid), 64'd0);
    chk("async reset wready", 64'(wready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post reset count", 64'(count), 64'd0);
    chk("post reset read_valid", 64'(read_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
